if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the PC register, the single-outstanding instruction-memory request, and the IF/ID pipeline register. Sits directly upstream of the decode stage. Consumes `PCWrite` and `Reg_IF_ID_Data` from the hazard detection unit, and the taken-branch redirect from EX. Produces the IF/ID contents read by decode and by the hazard unit's rs1/rs2 compare.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_skid_buf.sv | 50 +++++
 rtl/if_fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end.
//   XLEN_DEFAULT  : default address / PC width
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   fetch_state_e : instruction-fetch sequencer states
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // issue a fetch for the current PC
        S_WAIT = 2'd1,  // request accepted, waiting for the response
        S_HOLD = 2'd2,  // response parked in the skid buffer during a stall
        S_DROP = 2'd3   // a redirect orphaned the outstanding response; discard it
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register. Parks a fetched word that arrived
// while decode was stalled so it is neither lost nor fetched twice.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_i            : capture pc_i / instr_i and mark the entry valid
//   clear_i           : empty the entry (wins over load_i)
//   pc_i, instr_i     : word to park
//   valid_o           : entry holds a word
//   pc_o, instr_o     : parked word
module if_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding instruction
// memory request, and the IF/ID pipeline register.
// Optional feature macro: IF_STALL_CNT_EN adds the stall_cnt output and a
// saturating 32-bit counter of stalled (non-flushed) cycles.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   PCWrite, Reg_IF_ID_Data      : from hazard unit, 0 = hold PC / hold IF/ID
//   ex_branch_taken/_target      : redirect + flush from EX
//   imem_req, imem_addr          : fetch request (accepted when high), address = PC
//   imem_rvalid, imem_rdata      : fetch response
//   id_pc, id_instr, id_valid    : IF/ID register contents
//   stall_cnt                    : stalled-cycle counter (IF_STALL_CNT_EN only)
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN      = riscv_pkg::XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            Reg_IF_ID_Data,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;

    logic            stall, flush;
    logic            skid_load, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            deliver;
    logic [XLEN-1:0] deliver_pc;
    logic [31:0]     deliver_instr;

    assign stall = !PCWrite || !Reg_IF_ID_Data;
    assign flush = ex_branch_taken;

    // A redirect in the request cycle suppresses the fetch of the stale PC.
    assign imem_req  = (state_q == S_REQ) && !flush && !rst;
    assign imem_addr = pc_q;

    if_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem_rdata;

        if (flush) begin
            pc_d       = ex_branch_target;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            skid_clear = 1'b1;
            // An in-flight response must be swallowed before refetching;
            // if it lands this very cycle it is simply ignored.
            case (state_q)
                S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && skid_valid) begin
                        deliver       = 1'b1;
                        deliver_pc    = skid_pc;
                        deliver_instr = skid_instr;
                        skid_clear    = 1'b1;
                        state_d       = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (deliver) begin
                id_pc_d    = deliver_pc;
                id_instr_d = deliver_instr;
                id_valid_d = 1'b1;
                pc_d       = pc_q + XLEN'(4);
            end else if (!stall) begin
                // Nothing to hand over: bubble, keeping the last id_pc.
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCWrite, Reg_IF_ID_Data, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        imem_req, imem_rvalid, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
    logic        imem_req2, id_valid2;
    logic [31:0] imem_addr2, id_pc2, id_instr2;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt2;
`endif

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Reg_IF_ID_Data(Reg_IF_ID_Data),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
`ifdef IF_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Same stimulus, PC starting just below the wrap point.
    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Reg_IF_ID_Data(Reg_IF_ID_Data),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .id_pc(id_pc2), .id_instr(id_instr2), .id_valid(id_valid2)
`ifdef IF_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_wrap = 1'b0;

    // Reference model: PC, whether a fetch is in flight, whether that fetch
    // was orphaned by a redirect, the parked word, and the IF/ID contents.
    logic [31:0] m_pc, m_skpc, m_skin, m_idpc, m_idin, m_cnt;
    bit          m_out, m_drop, m_skv, m_idv;

    // Memory environment
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min = 1, lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_drop = 0; m_skv = 0;
        m_idpc = 32'h0; m_idin = NOP_INSTR; m_idv = 0; m_cnt = 32'h0;
    endtask

    // One clock: drive memory response, check outputs, advance model.
    // Called at a negedge with control inputs already set.
    task automatic step();
        bit          stall, flush, req_exp, have;
        logic [31:0] wpc, win;
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
        #1;
        stall   = !PCWrite || !Reg_IF_ID_Data;
        flush   = ex_branch_taken;
        req_exp = !rst && !m_out && !m_skv && !flush;
        chk("imem_req",  {31'b0, imem_req}, {31'b0, req_exp});
        chk("imem_addr", imem_addr, m_pc);
        chk("id_pc",     id_pc,     m_idpc);
        chk("id_instr",  id_instr,  m_idin);
        chk("id_valid",  {31'b0, id_valid}, {31'b0, m_idv});
`ifdef IF_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
        if (chk_wrap) chk("imem_addr_wrap", imem_addr2, m_pc + 32'hFFFF_FFFC);

        have = 0; wpc = 32'h0; win = 32'h0;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_pc = ex_branch_target; m_idpc = 32'h0; m_idin = NOP_INSTR; m_idv = 0; m_skv = 0;
            if (m_out) begin
                if (imem_rvalid) begin m_out = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (m_out && imem_rvalid) begin
                m_out = 0;
                if (!m_drop) begin have = 1; wpc = m_pc; win = imem_rdata; end
                m_drop = 0;
            end else if (req_exp) begin
                m_out = 1; m_drop = 0;
            end
            if (m_skv) begin have = 1; wpc = m_skpc; win = m_skin; end
            if (stall) begin
                if (have && !m_skv) begin m_skv = 1; m_skpc = wpc; m_skin = win; end
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else if (have) begin
                m_idpc = wpc; m_idin = win; m_idv = 1; m_pc = m_pc + 4; m_skv = 0;
            end else begin
                m_idin = NOP_INSTR; m_idv = 0;
            end
        end

        if (rst) begin
            mem_pend = 0;
        end else begin
            if (imem_rvalid) mem_pend = 0;
            if (imem_req) begin
                mem_pend = 1; mem_addr = imem_addr;
                mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            end else if (mem_pend && mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the DUT has just issued a request (now waiting).
    task automatic reach_wait();
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            seen = imem_req;
            step();
        end
        chk("reach_wait", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        rst = 1; PCWrite = 1; Reg_IF_ID_Data = 1; ex_branch_taken = 0;
        ex_branch_target = 32'h0; imem_rvalid = 0; imem_rdata = 32'h0; mem_pend = 0;
        @(posedge clk); @(negedge clk);
        model_reset();
        chk_wrap = 1;

        // Reset state, then back-to-back fetches with latency 1
        repeat (2) step();
        rst = 0;
        repeat (6) step();

        // Three-cycle stall while a response lands
        PCWrite = 0; Reg_IF_ID_Data = 0;
        repeat (3) step();
        PCWrite = 1; Reg_IF_ID_Data = 1;
        repeat (4) step();
        chk_wrap = 0;

        // Redirect while waiting, response 2 cycles later is dropped
        lat_min = 2; lat_max = 2;
        reach_wait();
        ex_branch_taken = 1; ex_branch_target = 32'h0000_0100;
        step();
        ex_branch_taken = 0;
        repeat (8) step();

        // Flush and stall in the same cycle
        lat_min = 1; lat_max = 1;
        reach_wait();
        PCWrite = 0; ex_branch_taken = 1; ex_branch_target = 32'h0000_0200;
        step();
        PCWrite = 1; ex_branch_taken = 0;
        repeat (5) step();

        // Reset in the middle of a transaction
        lat_min = 3; lat_max = 3;
        reach_wait();
        rst = 1;
        repeat (2) step();
        rst = 0;
        repeat (6) step();

        // Randomized traffic
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 800; i++) begin
            int r;
            rst            = ($urandom_range(99) == 0);
            PCWrite        = ($urandom_range(99) >= 15);
            Reg_IF_ID_Data = ($urandom_range(99) >= 15);
            ex_branch_taken = ($urandom_range(99) < 6);
            r = int'($urandom_range(3));
            ex_branch_target = (r == 0) ? 32'hFFFF_FFFC :
                               (r == 1) ? $urandom : ($urandom & 32'h0000_0FFC);
            step();
        end
        rst = 0; PCWrite = 1; Reg_IF_ID_Data = 1; ex_branch_taken = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
